// File: rtl/hamming_mutator_pkg.sv
// Shared definitions for hamming_mutator: FSM encoding, LFSR polynomial and reset seed.
package hamming_mutator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1 (maximal length).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mutator_lfsr.sv
// 16-bit Galois LFSR that advances every cycle; optional parallel load with a zero-seed guard.
module mutator_lfsr
  import hamming_mutator_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Seed,
  output logic [15:0] Value
);

  logic [15:0] r_lfsr;

  // An all-zero state would lock the register, so a zero seed falls back to the reset seed.
  always_ff @(posedge Clk) begin
    if (Reset)     r_lfsr <= LFSR_SEED;
    else if (Load) r_lfsr <= (Seed == 16'h0000) ? LFSR_SEED : Seed;
    else           r_lfsr <= lfsr_step(r_lfsr);
  end

  assign Value = r_lfsr;

endmodule

// File: rtl/hamming_mutator.sv
// Flips exactly Distance distinct, pseudo-randomly chosen bits of Word.
// Define HAMMING_MUTATOR_SEED_EN to add the SeedLoad/Seed ports for reseeding the LFSR.
module hamming_mutator
  import hamming_mutator_pkg::*;
#(
  parameter int Width     = 8,
  parameter int DiffWidth = $clog2(Width)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [Width-1:0]     Word,
  input  logic [DiffWidth-1:0] Distance,
`ifdef HAMMING_MUTATOR_SEED_EN
  input  logic                 SeedLoad,
  input  logic [15:0]          Seed,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [Width-1:0]     Mutant
);

  localparam int IdxW = $clog2(Width);

  state_t               r_state, w_state_nxt;
  logic [Width-1:0]     r_word;
  logic [Width-1:0]     r_mask;
  logic [DiffWidth-1:0] r_remaining;
  logic [Width-1:0]     r_mutant;

  logic [15:0]          w_lfsr;
  logic                 w_lfsr_load;
  logic [15:0]          w_lfsr_seed;
  logic [IdxW-1:0]      w_idx;
  logic [Width-1:0]     w_bit;
  logic                 w_hit;
  logic                 w_last;
  logic [Width-1:0]     w_mask_set;
  logic                 w_unused_lfsr;

`ifdef HAMMING_MUTATOR_SEED_EN
  assign w_lfsr_load = SeedLoad;
  assign w_lfsr_seed = Seed;
`else
  assign w_lfsr_load = 1'b0;
  assign w_lfsr_seed = 16'h0000;
`endif

  mutator_lfsr u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (w_lfsr_load),
    .Seed  (w_lfsr_seed),
    .Value (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:IdxW];
  assign w_idx         = w_lfsr[IdxW-1:0];
  assign w_bit         = {{(Width-1){1'b0}}, 1'b1} << w_idx;
  assign w_hit         = r_mask[w_idx];
  assign w_last        = !w_hit && (r_remaining == DiffWidth'(1));
  assign w_mask_set    = r_mask | w_bit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_nxt = (Distance == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Mutant is written only on the edge that enters DONE and otherwise holds.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_mask      <= '0;
      r_remaining <= '0;
      r_mutant    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_word      <= Word;
            r_mask      <= '0;
            r_remaining <= Distance;
            if (Distance == '0) r_mutant <= Word;
          end
        end
        ST_RUN: begin
          if (!w_hit) begin
            r_mask      <= w_mask_set;
            r_remaining <= r_remaining - DiffWidth'(1);
            if (w_last) r_mutant <= r_word ^ w_mask_set;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy   = (r_state != ST_IDLE);
  assign Done   = (r_state == ST_DONE);
  assign Mutant = r_mutant;

endmodule

// File: tb/tb_hamming_mutator.sv
// Directed bench for hamming_mutator (Width=8) with an independent LFSR/selection model.
module tb_hamming_mutator;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Word = 8'h00;
  logic [2:0] Distance = 3'd0;
  logic       Busy, Done;
  logic [7:0] Mutant;
`ifdef HAMMING_MUTATOR_SEED_EN
  logic        SeedLoad = 1'b0;
  logic [15:0] Seed = 16'h0000;
`endif

  hamming_mutator #(.Width(8), .DiffWidth(3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Word     (Word),
    .Distance (Distance),
`ifdef HAMMING_MUTATOR_SEED_EN
    .SeedLoad (SeedLoad),
    .Seed     (Seed),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .Mutant   (Mutant)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 16'hACE1;
`ifdef HAMMING_MUTATOR_SEED_EN
    else if (SeedLoad) m_lfsr <= (Seed == 16'h0000) ? 16'hACE1 : Seed;
`endif
    else m_lfsr <= m_step(m_lfsr);
  end

  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  // l0 is the LFSR value present when Start is sampled.
  function automatic logic [7:0] model_mutant(input logic [7:0] w, input logic [2:0] d,
                                              input logic [15:0] l0, output int lat);
    logic [15:0] l;
    logic [7:0]  mask;
    int          rem;
    l    = m_step(l0);
    mask = 8'h00;
    rem  = d;
    lat  = 1;
    while (rem > 0) begin
      if (!mask[l[2:0]]) begin
        mask[l[2:0]] = 1'b1;
        rem--;
      end
      l = m_step(l);
      lat++;
    end
    return w ^ mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input string tag, inout int lat);
    while (Done !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    chk({tag, "_done_seen"}, Done, 1'b1);
  endtask

  task automatic do_request(input string tag, input logic [7:0] w, input logic [2:0] d,
                            output logic [7:0] mut);
    int          c0;
    int          lat;
    int          exp_lat;
    logic [7:0]  exp_mut;
    c0      = done_cnt;
    exp_mut = model_mutant(w, d, m_lfsr, exp_lat);
    Start = 1'b1; Word = w; Distance = d;
    step();
    Start = 1'b0; Word = 8'($urandom); Distance = 3'($urandom);
    lat = 1;
    wait_done(tag, lat);
    mut = Mutant;
    chk({tag, "_mutant"}, Mutant, exp_mut);
    chk({tag, "_distance"}, $countones(w ^ Mutant), d);
    chk({tag, "_latency"}, lat, exp_lat);
    step();
    chk({tag, "_idle"}, {Busy, Done}, 2'b00);
    chk({tag, "_one_pulse"}, done_cnt, c0 + 1);
  endtask

  logic [7:0] mut_a, mut_b;
  int         lat;
  int         c0;
  logic [7:0] exp_mut;
  int         exp_lat;
  logic [15:0] l0;
`ifdef HAMMING_MUTATOR_SEED_EN
  logic [7:0] seq_a [3];
  logic [7:0] seq_b [3];
`endif

  initial begin
    // Reset state
    step();
    step();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_mutant", Mutant, 8'h00);
    chk("rst_lfsr", dut.u_lfsr.Value, 16'hACE1);
    Reset = 1'b0;
    step();
    step();
    chk("lfsr_adv", dut.u_lfsr.Value, m_lfsr);

    // Distance 0: Done one cycle after Start, word unchanged, Busy for one cycle
    Start = 1'b1; Word = 8'hA5; Distance = 3'd0;
    c0 = done_cnt;
    step();
    Start = 1'b0; Word = 8'h3C;
    chk("d0_done", Done, 1'b1);
    chk("d0_busy", Busy, 1'b1);
    chk("d0_mutant", Mutant, 8'hA5);
    step();
    chk("d0_busy_low", Busy, 1'b0);
    chk("d0_pulses", done_cnt, c0 + 1);

    do_request("w00_d7", 8'h00, 3'd7, mut_a);
    chk("w00_d7_popcount", $countones(mut_a), 7);
    do_request("wF0_d3", 8'hF0, 3'd3, mut_a);
    do_request("w5A_d1", 8'h5A, 3'd1, mut_a);

    // Start re-asserted during RUN must be ignored
    c0 = done_cnt;
    l0 = m_lfsr;
    exp_mut = model_mutant(8'h3C, 3'd6, l0, exp_lat);
    Start = 1'b1; Word = 8'h3C; Distance = 3'd6;
    step();
    Start = 1'b0;
    step();
    Start = 1'b1; Word = 8'hFF; Distance = 3'd1;
    step();
    step();
    Start = 1'b0;
    lat = 3;
    wait_done("ign", lat);
    chk("ign_mutant", Mutant, exp_mut);
    chk("ign_distance", $countones(8'h3C ^ Mutant), 6);
    step();
    chk("ign_idle", Busy, 1'b0);
    step();
    chk("ign_pulses", done_cnt, c0 + 1);

    // Reset two cycles into RUN aborts silently
    c0 = done_cnt;
    Start = 1'b1; Word = 8'hC3; Distance = 3'd5;
    step();
    Start = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_mutant", Mutant, 8'h00);
    chk("abort_lfsr", dut.u_lfsr.Value, 16'hACE1);
    repeat (10) step();
    chk("abort_no_pulse", done_cnt, c0);

    // Reset wins over Start in the same cycle
    Reset = 1'b1; Start = 1'b1; Word = 8'h11; Distance = 3'd2;
    step();
    Reset = 1'b0; Start = 1'b0;
    chk("rst_prio_busy", Busy, 1'b0);

    // Random requests
    c0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      do_request("rand", 8'($urandom), 3'($urandom_range(0, 7)), mut_a);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (5) step();
    chk("rand_total_pulses", done_cnt, c0 + 100);
    chk("lfsr_track", dut.u_lfsr.Value, m_lfsr);

`ifdef HAMMING_MUTATOR_SEED_EN
    SeedLoad = 1'b1; Seed = 16'h0000;
    step();
    SeedLoad = 1'b0;
    chk("seed_zero", dut.u_lfsr.Value, 16'hACE1);
    for (int pass = 0; pass < 2; pass++) begin
      SeedLoad = 1'b1; Seed = 16'h1234;
      step();
      SeedLoad = 1'b0;
      chk("seed_load", dut.u_lfsr.Value, 16'h1234);
      do_request("seed0", 8'hA5, 3'd4, mut_b);
      if (pass == 0) seq_a[0] = mut_b; else seq_b[0] = mut_b;
      do_request("seed1", 8'h3C, 3'd5, mut_b);
      if (pass == 0) seq_a[1] = mut_b; else seq_b[1] = mut_b;
      do_request("seed2", 8'h0F, 3'd3, mut_b);
      if (pass == 0) seq_a[2] = mut_b; else seq_b[2] = mut_b;
    end
    for (int k = 0; k < 3; k++) chk("seed_repeat", seq_b[k], seq_a[k]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_mutator.md
HAMMING_MUTATOR -- requirements
Module: hamming_mutator

Interface
REQ-001 SHALL have parameter Width, default 8: word width in bits, power of two, 4..64.
REQ-002 SHALL have parameter DiffWidth, default $clog2(Width): width of the Distance port.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Clk  input  1: sole clock, rising edge.
REQ-005 Reset  input  1: synchronous, active-high.
REQ-006 Start  input  1: request pulse, sampled only in IDLE.
REQ-007 Word  input  Width: source word.
REQ-008 Distance  input  DiffWidth: number of bits to flip.
REQ-009 Busy  output  1: high while a request is in progress (RUN and DONE).
REQ-010 Done  output  1: one-cycle completion pulse.
REQ-011 Mutant  output  Width: result word; Hamming distance from the latched Word equals the latched Distance.

Function
REQ-012 SHALL implement three states: IDLE, RUN, DONE.
REQ-013 In IDLE with Start=1, SHALL latch Word and Distance, clear the flip mask and set Busy=1 at the same edge.
- Next state is RUN if Distance!=0.
- Next state is DONE if Distance==0.
REQ-014 In RUN, each cycle:
- idx = Lfsr[$clog2(Width)-1:0].
- If Mask[idx]==0: set Mask[idx] and decrement Remaining.
- If Mask[idx]==1: retry next cycle with no change.
REQ-015 When the set in RUN makes Remaining reach 0, the next state SHALL be DONE.
REQ-016 On the edge entering DONE, SHALL register Mutant = latched Word XOR Mask.
REQ-017 In DONE, Done=1 for exactly one cycle, then return to IDLE with Busy=0.
REQ-018 Mutant SHALL hold its value until the next completion or Reset.
REQ-019 Start SHALL be ignored while Busy=1, with no queuing.
REQ-020 Word and Distance changes after acceptance SHALL not affect the request in progress.
REQ-021 The 16-bit Galois LFSR SHALL use taps x^16+x^14+x^13+x^11, advance every cycle in every state, and reset to 16'hACE1.
REQ-022 Latency from the Start edge to the Done cycle SHALL be 1 cycle for Distance=0 and at least Distance+1 cycles otherwise; it is bounded because the LFSR is maximal-length.
REQ-023 The mask SHALL never set more than Distance bits, so flipped bits are always distinct.

Reset
REQ-024 On Reset=1 at a rising edge:
- state=IDLE; Busy=0; Done=0; Mutant=0; Mask=0; Remaining=0; LFSR=16'hACE1.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the request with no Done pulse.
REQ-026 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-027 With HAMMING_MUTATOR_SEED_EN defined:
- Adds ports SeedLoad (input, 1) and Seed (input, 16).
- SeedLoad=1 loads Seed into the LFSR at that edge, overriding the advance.
- Seed=0 loads 16'hACE1 instead.
- Reset still has priority.
REQ-028 Without HAMMING_MUTATOR_SEED_EN: these ports are absent and the LFSR is reset-seeded only.

Structure
REQ-029 Shared package hamming_mutator_pkg SHALL hold the state encoding, the LFSR tap constant and the reset seed 16'hACE1.
REQ-030 The LFSR SHALL be a sub-module, mutator_lfsr, with ports Clk, Reset, Load, Seed and Value.
REQ-031 The remaining RTL is a single FSM module.

Verification
REQ-032 Width=8, Word=8'hA5, Distance=0, Start -> Done in the next cycle, Mutant=8'hA5, Busy high for 1 cycle.
REQ-033 Width=8, Word=8'h00, Distance=7 -> popcount(Mutant)=7, Diff module (Word, Mutant) reports 7, exactly one Done pulse.
REQ-034 Width=8, 100 random Word/Distance requests -> Diff(Word, Mutant)==Distance for every request, no Done pulse without a Start.
REQ-035 Start re-asserted during RUN with Word=8'hFF -> ignored; Mutant derives from the first Word only.
REQ-036 Reset asserted 2 cycles into RUN with Distance=5 -> Busy=0, Done never pulses, Mutant=0, LFSR=16'hACE1 next cycle.
REQ-037 HAMMING_MUTATOR_SEED_EN defined, Seed=16'h1234 loaded, then identical requests repeated after reload -> bit-identical Mutant sequences.
